spi_reg_ctrl: RTL

Transaction controller sitting directly behind the SPI slave receiver. It consumes 24-bit words delivered by the receiver's `data_ready` strobe, decodes each as an address/data register write, and stages the writes in a shadow bank. On the end of the transfer (chip-select release), it commits all staged writes atomically to the active register outputs that configure the pulse datapath. Malformed transfers are discarded whole.

---
 rtl/spi_reg_pkg.sv | 22 ++
 rtl/spi_reg_ctrl_if.sv | 30 +++
 rtl/spi_shadow_bank.sv | 53 +++++
 rtl/spi_reg_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared widths, FSM state type and word field helpers for the SPI register controller.
package spi_reg_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int WORD_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DISCARD = 2'd2
    } spi_reg_state_t;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] word_data(input logic [WORD_W-1:0] w);
        return w[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Bus between the SPI receiver side and the register controller.
interface spi_reg_ctrl_if #(
    parameter int NUM_REGS = 16
);
    import spi_reg_pkg::*;

    // rx_valid/rx_start/rx_end are single-cycle strobes with no backpressure:
    // the controller consumes every strobe in the cycle it is presented.
    logic [WORD_W-1:0]                rx_word;
    logic                             rx_valid;
    logic                             rx_start;
    logic                             rx_end;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
    logic                             commit;
    logic                             frame_error;
    logic                             busy;
    logic [7:0]                       commit_count;
    spi_reg_state_t                   state;

    modport master (
        output rx_word, rx_valid, rx_start, rx_end,
        input  regs, commit, frame_error, busy, commit_count, state
    );

    modport slave (
        input  rx_word, rx_valid, rx_start, rx_end,
        output regs, commit, frame_error, busy, commit_count, state
    );

endinterface

// File: rtl/spi_shadow_bank.sv
// Shadow register storage with dirty mask; a commit copies only dirty entries to the active bank.
module spi_shadow_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_wr_en,
    input  logic [ADDR_W-1:0]               i_wr_addr,
    input  logic [DATA_W-1:0]               i_wr_data,
    input  logic                            i_clear,
    input  logic                            i_commit,
    output logic [NUM_REGS-1:0][DATA_W-1:0] o_regs
);

    logic [NUM_REGS-1:0][DATA_W-1:0] r_shadow;
    logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
    logic [NUM_REGS-1:0]             r_dirty;
    logic [NUM_REGS-1:0][DATA_W-1:0] w_shadow_next;
    logic [NUM_REGS-1:0]             w_dirty_next;

    // A write landing in the same cycle as the commit must be part of that commit.
    always_comb begin
        w_shadow_next = r_shadow;
        w_dirty_next  = r_dirty;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_wr_en && (i_wr_addr == ADDR_W'(i))) begin
                w_shadow_next[i] = i_wr_data;
                w_dirty_next[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
            r_regs   <= '0;
            r_dirty  <= '0;
        end else begin
            r_shadow <= w_shadow_next;
            r_dirty  <= (i_clear || i_commit) ? '0 : w_dirty_next;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_commit && w_dirty_next[i]) begin
                    r_regs[i] <= w_shadow_next[i];
                end
            end
        end
    end

    assign o_regs = r_regs;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI transaction controller: stages address/data writes per transfer and commits them atomically on chip-select release.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int MAX_WORDS = 32
) (
    input  logic          clk,
    input  logic          reset,
    spi_reg_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    spi_reg_state_t                  r_state;
    spi_reg_state_t                  w_state_next;
    logic [CNT_W-1:0]                r_count;
    logic [CNT_W-1:0]                w_count_next;
    logic                            r_commit;
    logic                            r_frame_error;
    logic                            r_busy;
    logic [7:0]                      r_commit_count;
    logic                            w_wr_en;
    logic                            w_clear;
    logic                            w_commit;
    logic                            w_frame_error;
    logic                            w_reject;
    logic                            w_addr_ok;
    logic                            w_room;
    logic [ADDR_W-1:0]               w_addr;
    logic [DATA_W-1:0]               w_data;
    logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;

    assign w_addr    = word_addr(bus.rx_word);
    assign w_data    = word_data(bus.rx_word);
    assign w_addr_ok = 32'(w_addr) < NUM_REGS;
    assign w_room    = 32'(r_count) < MAX_WORDS;

    // Within one cycle: the word is handled first, then the end strobe, then the start strobe.
    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_wr_en       = 1'b0;
        w_clear       = 1'b0;
        w_commit      = 1'b0;
        w_frame_error = 1'b0;
        w_reject      = 1'b0;
        case (r_state)
            ST_IDLE: begin
            end
            ST_RECV: begin
                if (bus.rx_valid) begin
                    if (w_addr_ok && w_room) begin
                        w_wr_en      = 1'b1;
                        w_count_next = r_count + 1'b1;
                    end else begin
                        w_reject     = 1'b1;
                        w_state_next = ST_DISCARD;
                    end
                end
                if (bus.rx_end) begin
                    if (w_reject) begin
                        w_frame_error = 1'b1;
                    end else if (w_count_next != '0) begin
                        w_commit = 1'b1;
                    end
                    w_state_next = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (bus.rx_end) begin
                    w_frame_error = 1'b1;
                    w_state_next  = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (bus.rx_start) begin
            // A start while a transfer is still open means its end strobe was lost.
            if (w_state_next != ST_IDLE) begin
                w_frame_error = 1'b1;
            end
            w_state_next = ST_RECV;
            w_count_next = '0;
            w_clear      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_commit       <= 1'b0;
            r_frame_error  <= 1'b0;
            r_busy         <= 1'b0;
            r_commit_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_commit      <= w_commit;
            r_frame_error <= w_frame_error;
            r_busy        <= (w_state_next != ST_IDLE);
            if (w_commit) begin
                r_commit_count <= r_commit_count + 8'd1;
            end
        end
    end

    spi_shadow_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_addr),
        .i_wr_data (w_data),
        .i_clear   (w_clear),
        .i_commit  (w_commit),
        .o_regs    (w_regs)
    );

    assign bus.regs         = w_regs;
    assign bus.commit       = r_commit;
    assign bus.frame_error  = r_frame_error;
    assign bus.busy         = r_busy;
    assign bus.commit_count = r_commit_count;
    assign bus.state        = r_state;

endmodule
